pong_frame_sequencer: RTL and testbench



---
 rtl/pong_frame_sequencer.sv | 140 ++++++++++++++
 tb/tb_pong_frame_sequencer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pong_frame_sequencer.sv
// Frame sequencer for the Motion Pong datapath: load origins, then loop
// draw ball/paddles -> wait ~1/60 s -> erase, with a per-shape watchdog.
module pong_frame_sequencer #(
  parameter int SHAPE_TIMEOUT = 128,
  parameter int FRAME_W       = 16
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               go,
  input  logic               pause,
  input  logic               fin_Wait,
  input  logic               fin_B_D,
  input  logic               fin_B_E,
  input  logic               fin_P1_D,
  input  logic               fin_P1_E,
  input  logic               fin_P2_D,
  input  logic               fin_P2_E,
  output logic [1:0]         sel_out,
  output logic [1:0]         sel_col,
  output logic               ld_bx,
  output logic               ld_by,
  output logic               ld_p1x,
  output logic               ld_p1y,
  output logic               ld_p2x,
  output logic               ld_p2y,
  output logic               en_B_shapeCounter_D,
  output logic               en_B_shapeCounter_E,
  output logic               en_P1_shapeCounter_D,
  output logic               en_P1_shapeCounter_E,
  output logic               en_P2_shapeCounter_D,
  output logic               en_P2_shapeCounter_E,
  output logic               en_delayCounter,
  output logic               plot,
  output logic               busy,
  output logic [FRAME_W-1:0] frame_count,
  output logic               timeout_err
);

  localparam int WD_W = (SHAPE_TIMEOUT > 2) ? $clog2(SHAPE_TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(SHAPE_TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_RESET, S_LOAD, S_IDLE,
    S_DRAW_B, S_DRAW_P1, S_DRAW_P2,
    S_WAIT, S_HOLD,
    S_ERASE_B, S_ERASE_P1, S_ERASE_P2
  } state_t;

  state_t              r_state, w_next;
  logic [WD_W-1:0]     r_wd;
  logic [FRAME_W-1:0]  r_frame_count;
  logic                r_timeout_err;
  logic                w_shape, w_fin, w_expire, w_adv, w_ld;

  // Only the fin belonging to the current shape state is looked at.
  always_comb begin
    w_shape = 1'b0;
    w_fin   = 1'b0;
    case (r_state)
      S_DRAW_B:   begin w_shape = 1'b1; w_fin = fin_B_D;  end
      S_DRAW_P1:  begin w_shape = 1'b1; w_fin = fin_P1_D; end
      S_DRAW_P2:  begin w_shape = 1'b1; w_fin = fin_P2_D; end
      S_ERASE_B:  begin w_shape = 1'b1; w_fin = fin_B_E;  end
      S_ERASE_P1: begin w_shape = 1'b1; w_fin = fin_P1_E; end
      S_ERASE_P2: begin w_shape = 1'b1; w_fin = fin_P2_E; end
      default:    ;
    endcase
    w_expire = w_shape && (r_wd == WD_MAX);
    w_adv    = w_fin || w_expire;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_RESET:    w_next = S_LOAD;
      S_LOAD:     w_next = S_IDLE;
      S_IDLE:     if (go)      w_next = S_DRAW_B;
      S_DRAW_B:   if (w_adv)   w_next = S_DRAW_P1;
      S_DRAW_P1:  if (w_adv)   w_next = S_DRAW_P2;
      S_DRAW_P2:  if (w_adv)   w_next = S_WAIT;
      S_WAIT:     if (fin_Wait) w_next = pause ? S_HOLD : S_ERASE_B;
      S_HOLD:     if (!pause)  w_next = S_ERASE_B;
      S_ERASE_B:  if (w_adv)   w_next = S_ERASE_P1;
      S_ERASE_P1: if (w_adv)   w_next = S_ERASE_P2;
      S_ERASE_P2: if (w_adv)   w_next = S_DRAW_B;
      default:    w_next = S_RESET;
    endcase
  end

  // Watchdog restarts on every state change, so it counts cycles-in-state minus one.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state       <= S_RESET;
      r_wd          <= '0;
      r_frame_count <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state <= w_next;
      r_wd    <= (w_next != r_state) ? '0 : r_wd + 1'b1;
      if (w_expire && !w_fin)         r_timeout_err <= 1'b1;
      if (r_state == S_WAIT && fin_Wait) r_frame_count <= r_frame_count + 1'b1;
    end
  end

  assign frame_count = r_frame_count;
  assign timeout_err = r_timeout_err;

  always_comb begin
    sel_out              = 2'd0;
    sel_col              = 2'd1;
    w_ld                 = 1'b0;
    en_B_shapeCounter_D  = 1'b0;
    en_B_shapeCounter_E  = 1'b0;
    en_P1_shapeCounter_D = 1'b0;
    en_P1_shapeCounter_E = 1'b0;
    en_P2_shapeCounter_D = 1'b0;
    en_P2_shapeCounter_E = 1'b0;
    en_delayCounter      = 1'b0;
    plot                 = 1'b0;
    busy                 = (r_state != S_RESET) && (r_state != S_IDLE);
    case (r_state)
      S_LOAD:     w_ld = 1'b1;
      S_DRAW_B:   begin sel_out = 2'd0; sel_col = 2'd0; en_B_shapeCounter_D  = 1'b1; plot = 1'b1; end
      S_DRAW_P1:  begin sel_out = 2'd1; sel_col = 2'd2; en_P1_shapeCounter_D = 1'b1; plot = 1'b1; end
      S_DRAW_P2:  begin sel_out = 2'd2; sel_col = 2'd2; en_P2_shapeCounter_D = 1'b1; plot = 1'b1; end
      S_WAIT:     en_delayCounter = 1'b1;
      S_ERASE_B:  begin sel_out = 2'd0; en_B_shapeCounter_E  = 1'b1; plot = 1'b1; end
      S_ERASE_P1: begin sel_out = 2'd1; en_P1_shapeCounter_E = 1'b1; plot = 1'b1; end
      S_ERASE_P2: begin sel_out = 2'd2; en_P2_shapeCounter_E = 1'b1; plot = 1'b1; end
      default:    ;
    endcase
    ld_bx  = w_ld;
    ld_by  = w_ld;
    ld_p1x = w_ld;
    ld_p1y = w_ld;
    ld_p2x = w_ld;
    ld_p2y = w_ld;
  end

endmodule

// File: tb/tb_pong_frame_sequencer.sv
// Randomized bench for pong_frame_sequencer: phase durations and strobes are
// checked against a frame-level model (shape latencies, wait/hold lengths).
module tb_pong_frame_sequencer;
  localparam int TO = 128;

  logic clock = 1'b0, resetn = 1'b1, go = 1'b0, pause = 1'b0, fin_Wait = 1'b0;
  logic fin_B_D = 1'b0, fin_B_E = 1'b0, fin_P1_D = 1'b0, fin_P1_E = 1'b0;
  logic fin_P2_D = 1'b0, fin_P2_E = 1'b0;
  logic [1:0] sel_out, sel_col;
  logic ld_bx, ld_by, ld_p1x, ld_p1y, ld_p2x, ld_p2y;
  logic en_B_D, en_B_E, en_P1_D, en_P1_E, en_P2_D, en_P2_E;
  logic en_delayCounter, plot, busy, timeout_err;
  logic [15:0] frame_count;

  pong_frame_sequencer #(.SHAPE_TIMEOUT(TO), .FRAME_W(16)) dut (
    .clock(clock), .resetn(resetn), .go(go), .pause(pause), .fin_Wait(fin_Wait),
    .fin_B_D(fin_B_D), .fin_B_E(fin_B_E), .fin_P1_D(fin_P1_D), .fin_P1_E(fin_P1_E),
    .fin_P2_D(fin_P2_D), .fin_P2_E(fin_P2_E),
    .sel_out(sel_out), .sel_col(sel_col),
    .ld_bx(ld_bx), .ld_by(ld_by), .ld_p1x(ld_p1x), .ld_p1y(ld_p1y),
    .ld_p2x(ld_p2x), .ld_p2y(ld_p2y),
    .en_B_shapeCounter_D(en_B_D), .en_B_shapeCounter_E(en_B_E),
    .en_P1_shapeCounter_D(en_P1_D), .en_P1_shapeCounter_E(en_P1_E),
    .en_P2_shapeCounter_D(en_P2_D), .en_P2_shapeCounter_E(en_P2_E),
    .en_delayCounter(en_delayCounter), .plot(plot), .busy(busy),
    .frame_count(frame_count), .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  // Shape order: 0 B_D, 1 P1_D, 2 P2_D, 3 B_E, 4 P1_E, 5 P2_E
  logic [5:0] w_ens, w_lds;
  assign w_ens = {en_P2_E, en_P1_E, en_B_E, en_P2_D, en_P1_D, en_B_D};
  assign w_lds = {ld_p2y, ld_p2x, ld_p1y, ld_p1x, ld_by, ld_bx};

  int total = 0, bad = 0;
  int exp_frames = 0;
  bit exp_to = 1'b0;
  int lat [6];
  int dur [6];
  int wdur, hdur, perr;

  function automatic int exp_dur(input int l);
    return (l >= 1 && l <= TO) ? l : TO;
  endfunction

  task automatic drive_fins(input logic [5:0] f, input logic fw);
    {fin_P2_E, fin_P1_E, fin_B_E, fin_P2_D, fin_P1_D, fin_B_D} = f;
    fin_Wait = fw;
  endtask

  // Called at the negedge of a shape state's first cycle; returns its length.
  task automatic run_shape(input int s, input int l, output int d);
    logic [5:0] nf;
    int eso, esc;
    d = 0;
    eso = s % 3;
    esc = (s >= 3) ? 1 : ((s == 0) ? 0 : 2);
    for (int k = 1; k <= 300; k++) begin
      if (w_ens[s] !== 1'b1) break;
      d++;
      if (plot !== 1'b1 || sel_out !== 2'(eso) || sel_col !== 2'(esc) ||
          w_ens !== (6'b1 << s) || en_delayCounter !== 1'b0 || busy !== 1'b1 ||
          w_lds !== 6'h00) perr++;
      nf = 6'($urandom);
      nf[s] = (k == l);
      drive_fins(nf, 1'($urandom));
      pause = 1'($urandom);
      go    = 1'($urandom);
      @(posedge clock); @(negedge clock);
    end
  endtask

  task automatic run_wait(input int w, input bit p, input int h);
    logic [15:0] fc0;
    wdur = 0; hdur = 0;
    for (int k = 1; k <= 300; k++) begin
      if (en_delayCounter !== 1'b1) break;
      wdur++;
      if (plot !== 1'b0 || w_ens !== 6'h00 || busy !== 1'b1 || w_lds !== 6'h00) perr++;
      drive_fins(6'($urandom), (k == w));
      pause = (k == w) ? p : 1'($urandom);
      @(posedge clock); @(negedge clock);
    end
    if (p) begin
      fc0 = frame_count;
      for (int k = 1; k <= 300; k++) begin
        if (plot !== 1'b0) break;
        hdur++;
        if (en_delayCounter !== 1'b0 || w_ens !== 6'h00 || busy !== 1'b1 ||
            frame_count !== fc0) perr++;
        drive_fins(6'($urandom), 1'($urandom));
        pause = (k < h);
        @(posedge clock); @(negedge clock);
      end
    end
  endtask

  task automatic run_frame(input int w, input bit p, input int h);
    perr = 0;
    for (int s = 0; s < 3; s++) run_shape(s, lat[s], dur[s]);
    run_wait(w, p, h);
    for (int s = 3; s < 6; s++) run_shape(s, lat[s], dur[s]);
    exp_frames = (exp_frames + 1) % 65536;
    for (int s = 0; s < 6; s++)
      if (!(lat[s] >= 1 && lat[s] <= TO)) exp_to = 1'b1;
  endtask

  // Frame-level checks shared in shape but written inline per scenario.
  task automatic test_reset;
    resetn = 1'b1; #1 resetn = 1'b0;
    repeat (3) @(negedge clock);
    total++;
    if (plot !== 0 || busy !== 0 || w_lds !== 0 || w_ens !== 0 || en_delayCounter !== 0) begin
      bad++; $display("FAIL reset_strobes: plot=%b busy=%b ld=%h en=%h dly=%b want all 0",
                      plot, busy, w_lds, w_ens, en_delayCounter);
    end
    total++;
    if (sel_out !== 2'd0 || sel_col !== 2'd1) begin
      bad++; $display("FAIL reset_sel: sel_out=%0d sel_col=%0d want 0/1", sel_out, sel_col);
    end
    total++;
    if (frame_count !== 16'd0 || timeout_err !== 1'b0) begin
      bad++; $display("FAIL reset_counters: frame=%0d to=%b want 0/0", frame_count, timeout_err);
    end
  endtask

  task automatic test_load_idle;
    go = 1'b0;
    resetn = 1'b1;
    @(posedge clock); @(negedge clock);
    total++;
    if (w_lds !== 6'h3F || busy !== 1'b1 || plot !== 1'b0) begin
      bad++; $display("FAIL load_cycle: ld=%h busy=%b plot=%b want 3f/1/0", w_lds, busy, plot);
    end
    @(posedge clock); @(negedge clock);
    total++;
    if (w_lds !== 6'h00) begin
      bad++; $display("FAIL load_once: ld=%h want 00", w_lds);
    end
    repeat (5) @(negedge clock);
    total++;
    if (busy !== 1'b0 || plot !== 1'b0 || w_ens !== 0 || en_delayCounter !== 0) begin
      bad++; $display("FAIL idle_hold: busy=%b plot=%b en=%h dly=%b want 0", busy, plot, w_ens, en_delayCounter);
    end
  endtask

  task automatic test_draw_wait_erase;
    go = 1'b1;
    @(posedge clock); @(negedge clock);
    for (int s = 0; s < 6; s++) lat[s] = 16;
    run_frame(5, 1'b0, 0);
    for (int s = 0; s < 6; s++) begin
      total++;
      if (dur[s] !== 16) begin bad++; $display("FAIL basic_shape%0d: len=%0d want 16", s, dur[s]); end
    end
    total++;
    if (wdur !== 5 || hdur !== 0) begin
      bad++; $display("FAIL basic_wait: wait=%0d hold=%0d want 5/0", wdur, hdur);
    end
    total++;
    if (perr !== 0) begin bad++; $display("FAIL basic_strobes: errs=%0d want 0", perr); end
    total++;
    if (frame_count !== 16'(exp_frames)) begin
      bad++; $display("FAIL basic_frame: got %0d want %0d", frame_count, exp_frames);
    end
  endtask

  task automatic test_pause;
    for (int s = 0; s < 6; s++) lat[s] = 1 + int'($urandom_range(0, 20));
    run_frame(3, 1'b1, 40);
    total++;
    if (wdur !== 3 || hdur !== 40) begin
      bad++; $display("FAIL pause_hold: wait=%0d hold=%0d want 3/40", wdur, hdur);
    end
    total++;
    if (perr !== 0) begin bad++; $display("FAIL pause_strobes: errs=%0d want 0", perr); end
    total++;
    if (frame_count !== 16'(exp_frames)) begin
      bad++; $display("FAIL pause_frame: got %0d want %0d", frame_count, exp_frames);
    end
  endtask

  // fin on the very cycle the watchdog expires is a normal advance.
  task automatic test_boundary;
    lat[0] = TO; lat[1] = TO - 1; lat[2] = 1; lat[3] = 1; lat[4] = TO; lat[5] = 2;
    run_frame(1, 1'b0, 0);
    for (int s = 0; s < 6; s++) begin
      total++;
      if (dur[s] !== exp_dur(lat[s])) begin
        bad++; $display("FAIL edge_shape%0d: len=%0d want %0d", s, dur[s], exp_dur(lat[s]));
      end
    end
    total++;
    if (wdur !== 1 || perr !== 0) begin
      bad++; $display("FAIL edge_wait: wait=%0d errs=%0d want 1/0", wdur, perr);
    end
    total++;
    if (timeout_err !== 1'b0) begin
      bad++; $display("FAIL edge_no_err: to=%b want 0", timeout_err);
    end
  endtask

  task automatic test_timeout;
    for (int s = 0; s < 6; s++) lat[s] = 4;
    lat[1] = 0;
    run_frame(2, 1'b0, 0);
    total++;
    if (dur[1] !== TO || dur[2] !== 4) begin
      bad++; $display("FAIL timeout_len: p1=%0d p2=%0d want %0d/4", dur[1], dur[2], TO);
    end
    total++;
    if (timeout_err !== 1'b1) begin bad++; $display("FAIL timeout_err: got %b want 1", timeout_err); end
    for (int s = 0; s < 6; s++) lat[s] = 2;
    run_frame(2, 1'b0, 0);
    total++;
    if (timeout_err !== 1'b1 || perr !== 0) begin
      bad++; $display("FAIL timeout_sticky: to=%b errs=%0d want 1/0", timeout_err, perr);
    end
  endtask

  task automatic test_random;
    int w, h, r;
    bit p;
    for (int f = 0; f < 10; f++) begin
      for (int s = 0; s < 6; s++) begin
        r = int'($urandom_range(0, 9));
        lat[s] = (r == 0) ? 0 : (r == 1) ? int'($urandom_range(120, 140)) : int'($urandom_range(1, 30));
      end
      w = int'($urandom_range(1, 20));
      p = 1'($urandom);
      h = int'($urandom_range(1, 30));
      run_frame(w, p, h);
      for (int s = 0; s < 6; s++) begin
        total++;
        if (dur[s] !== exp_dur(lat[s])) begin
          bad++; $display("FAIL rand%0d_shape%0d: len=%0d want %0d", f, s, dur[s], exp_dur(lat[s]));
        end
      end
      total++;
      if (wdur !== w || hdur !== (p ? h : 0) || perr !== 0) begin
        bad++; $display("FAIL rand%0d_wait: wait=%0d hold=%0d errs=%0d want %0d/%0d/0",
                        f, wdur, hdur, perr, w, p ? h : 0);
      end
      total++;
      if (frame_count !== 16'(exp_frames) || timeout_err !== exp_to) begin
        bad++; $display("FAIL rand%0d_state: frame=%0d to=%b want %0d/%b",
                        f, frame_count, timeout_err, exp_frames, exp_to);
      end
    end
  endtask

  task automatic test_reset_mid;
    perr = 0;
    run_shape(0, 3, dur[0]);
    run_shape(1, 3, dur[1]);
    total++;
    if (en_P2_D !== 1'b1 || plot !== 1'b1) begin
      bad++; $display("FAIL mid_pre: en_P2_D=%b plot=%b want 1/1", en_P2_D, plot);
    end
    #2 resetn = 1'b0;
    #1;
    total++;
    if (plot !== 1'b0 || en_P2_D !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL mid_async: plot=%b en_P2_D=%b busy=%b want 0", plot, en_P2_D, busy);
    end
    exp_frames = 0; exp_to = 1'b0;
    drive_fins(6'h00, 1'b0);
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    @(posedge clock); @(negedge clock);
    total++;
    if (w_lds !== 6'h3F) begin bad++; $display("FAIL mid_reload: ld=%h want 3f", w_lds); end
    @(posedge clock); @(negedge clock);
    total++;
    if (frame_count !== 16'(exp_frames) || timeout_err !== exp_to) begin
      bad++; $display("FAIL mid_cleared: frame=%0d to=%b want 0/0", frame_count, timeout_err);
    end
  endtask

  initial begin
    test_reset;
    test_load_idle;
    test_draw_wait_erase;
    test_pause;
    test_boundary;
    test_timeout;
    test_random;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
